// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 transmitter: CPU pushes bytes into a small FIFO, polls STATUS; TXD starts one edge after a write into an idle, empty block.
// Writes to a full FIFO are dropped and set sticky OVF; define MMIO_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [7:0] ADDR,
  input  logic [7:0] DATA,
  input  logic       MW,
  output logic [7:0] Q,
  output logic       SEL,
  output logic       TXD,
  output logic       BUSY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [7:0]    STAT_ADDR = BASE_ADDR + 8'd1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [7:0]    last_q;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d, bit_nxt;
  logic [7:0]    byte_q, byte_d;
  logic          txd_q, txd_d;

  logic empty, full, push_req, push_ok, ovf_clr, pop, bit_end;
  logic [7:0] head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign head     = mem[rd_ptr_q];
  assign push_req = MW && (ADDR == BASE_ADDR);
  // A full FIFO still accepts a byte when the serialiser frees a slot on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_clr  = MW && (ADDR == STAT_ADDR) && DATA[3];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;

  assign SEL  = (ADDR == BASE_ADDR) || (ADDR == STAT_ADDR);
  assign TXD  = txd_q;
  assign BUSY = (state_q != S_IDLE) || !empty;

  always_comb begin
    Q = 8'h00;
    if (ADDR == BASE_ADDR)
      Q = last_q;
    else if (ADDR == STAT_ADDR)
      Q = {3'b000, PAR_EN, ovf_q, full, empty, BUSY};
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_q] <= DATA;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        last_q   <= DATA;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)
        count_q <= count_q + CW'(1);
      else if (pop && !push_ok)
        count_q <= count_q - CW'(1);
      if (push_req && !push_ok)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
    end
  end

  // TXD is registered from the next-state decision so the line moves on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    if (state_q != S_IDLE)
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          byte_d  = head;
          baud_d  = '0;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          txd_d   = byte_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^byte_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            txd_d = byte_q[bit_nxt];
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            byte_d  = head;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a per-cycle line-waveform model plus directed scenarios with literal expectations.
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic M_PAR = 1'b1;
`else
  localparam logic M_PAR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic [7:0] ADDR, DATA, Q;
  logic       MW, SEL, TXD, BUSY;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc = 0;

  mmio_uart_tx #(.BASE_ADDR(8'hF0), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ADDR(ADDR), .DATA(DATA), .MW(MW),
    .Q(Q), .SEL(SEL), .TXD(TXD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // Model: queued bytes, and the exact line level expected for each remaining cycle of the current frame.
  logic [7:0] mq[$];
  logic       sq[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_popped;
  int         m_pre;
  logic [7:0] m_b;

  function automatic logic m_busy();
    return (sq.size() != 0) || (mq.size() != 0);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'hF0) return m_last;
    if (a == 8'hF1) return {3'b000, M_PAR, m_ovf, mq.size() == DEPTH, mq.size() == 0, m_busy()};
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      mq.delete();
      sq.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      m_popped = 1'b0;
      m_pre    = mq.size();
      if (sq.size() > 0) void'(sq.pop_front());
      if (sq.size() == 0 && m_pre > 0) begin
        m_b = mq.pop_front();
        m_popped = 1'b1;
        for (int k = 0; k < CPB; k++) sq.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < CPB; k++) sq.push_back(m_b[i]);
`ifdef MMIO_UART_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) sq.push_back(^m_b);
`endif
        for (int k = 0; k < CPB; k++) sq.push_back(1'b1);
      end
      if (MW && ADDR == 8'hF0) begin
        if (m_pre < DEPTH || m_popped) begin
          mq.push_back(DATA);
          m_last = DATA;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (MW && ADDR == 8'hF1 && DATA[3]) begin
        m_ovf = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("txd", {7'd0, TXD}, {7'd0, (sq.size() != 0) ? sq[0] : 1'b1});
    chk("busy", {7'd0, BUSY}, {7'd0, m_busy()});
    chk("sel", {7'd0, SEL}, {7'd0, (ADDR == 8'hF0) || (ADDR == 8'hF1)});
    chk("q", Q, m_read(ADDR));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  int n;
  logic [9:0] frame;
  logic [7:0] ovf_vals [6];
  bit idle_seen;

  initial begin
    RESET_L = 1'b0; MW = 1'b0; ADDR = 8'h00; DATA = 8'h00;
    repeat (3) tick();
    chk("rst_txd", {7'd0, TXD}, 8'h01);
    chk("rst_busy", {7'd0, BUSY}, 8'h00);
    ADDR = 8'hF1; #1 chk("rst_status", Q, 8'h02);
    ADDR = 8'hF0; #1 chk("rst_last", Q, 8'h00);
    tick();
    RESET_L = 1'b1;
    repeat (2) tick();

    // Address miss: writes just outside the window must not touch the FIFO.
    MW = 1'b1; DATA = 8'h77; ADDR = 8'hF2;
    #1 chk("miss_f2_sel", {7'd0, SEL}, 8'h00);
    chk("miss_f2_q", Q, 8'h00);
    tick();
    ADDR = 8'hEF;
    #1 chk("miss_ef_sel", {7'd0, SEL}, 8'h00);
    chk("miss_ef_q", Q, 8'h00);
    tick();
    MW = 1'b0; ADDR = 8'hF1;
    #1 chk("miss_status", Q, 8'h02);
    tick();

    // Single byte 0x55: start, LSB-first data, stop, then idle.
    ADDR = 8'hF0; DATA = 8'h55; MW = 1'b1; n = cyc + 1;
    tick();
    MW = 1'b0; ADDR = 8'hF1;
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 1; j <= 40; j++) begin
      wait_until(n + j);
      chk("single_txd", {7'd0, TXD}, {7'd0, frame[(j - 1) / CPB]});
    end
    chk("single_busy_n40", {7'd0, BUSY}, 8'h01);
    wait_until(n + 41);
    chk("single_txd_idle", {7'd0, TXD}, 8'h01);
    chk("single_busy_n41", {7'd0, BUSY}, 8'h00);
    tick();

    // Back-to-back: second start bit directly follows the first stop bit.
    ADDR = 8'hF0; DATA = 8'hA1; MW = 1'b1; n = cyc + 1;
    tick();
    DATA = 8'h3C;
    tick();
    MW = 1'b0; ADDR = 8'hF1;
    wait_until(n + 40);
    chk("b2b_stop1", {7'd0, TXD}, 8'h01);
    wait_until(n + 41);
    chk("b2b_start2", {7'd0, TXD}, 8'h00);
    wait_until(n + 80);
    chk("b2b_busy_n80", {7'd0, BUSY}, 8'h01);
    wait_until(n + 81);
    chk("b2b_busy_n81", {7'd0, BUSY}, 8'h00);
    tick();

    // Overflow: six writes in a row, the first is popped early, the sixth is dropped.
    ovf_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ADDR = 8'hF0; MW = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DATA = ovf_vals[i];
      tick();
    end
    MW = 1'b0; ADDR = 8'hF1;
    #1 chk("ovf_status", Q, 8'h0D);
    tick();
    MW = 1'b1; DATA = 8'h08;
    tick();
    MW = 1'b0;
    #1 chk("ovf_cleared", Q, 8'h05);
    ADDR = 8'hF0;
    #1 chk("ovf_last", Q, 8'h55);
    ADDR = 8'hF1;
    idle_seen = 1'b0;
    for (int k = 0; k < 400 && !idle_seen; k++) begin
      tick();
      if (!BUSY) idle_seen = 1'b1;
    end
    chk("ovf_drain_timeout", {7'd0, idle_seen}, 8'h01);
    tick();

    // Reset mid-frame: line returns high at once and the queue is discarded.
    ADDR = 8'hF0; DATA = 8'hC3; MW = 1'b1;
    tick();
    DATA = 8'h5A;
    tick();
    MW = 1'b0;
    repeat (10) tick();
    RESET_L = 1'b0;
    #1 chk("midrst_txd", {7'd0, TXD}, 8'h01);
    chk("midrst_busy", {7'd0, BUSY}, 8'h00);
    ADDR = 8'hF1; #1 chk("midrst_status", Q, 8'h02);
    ADDR = 8'hF0; #1 chk("midrst_last", Q, 8'h00);
    tick();
    RESET_L = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", {7'd0, BUSY}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
